// File: rtl/collision_tracker.sv
// Multi-obstacle collision tracker: one hit per obstacle pass, lives, invulnerability window, game over.
// Optional macro COLLISION_JUMP_EN: airborne player clears low barriers.
module collision_tracker #(
  parameter int N_OBST        = 4,
  parameter int VWIDTH        = 12,
  parameter int LWIDTH        = 2,
  parameter int COUNT_WIDTH   = 16,
  parameter int POS_MISMATCH  = 0,
  parameter int POS_OFFSET    = 5,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 30,
  localparam int IW = (N_OBST > 1) ? $clog2(N_OBST) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     restart,
  input  logic [LWIDTH-1:0]        player_lane,
  input  logic signed [VWIDTH-1:0] player_voffset,
  input  logic                     player_air,
  input  logic [N_OBST-1:0]        obst_valid,
  input  logic [LWIDTH-1:0]        obst_lane [N_OBST],
  input  logic signed [VWIDTH-1:0] obst_voffset [N_OBST],
  input  logic [N_OBST-1:0]        obst_low,
  output logic                     hit_pulse,
  output logic [IW-1:0]            hit_idx,
  output logic [COUNT_WIDTH-1:0]   hit_count,
  output logic [3:0]               lives,
  output logic                     invuln,
  output logic                     game_over
);

  localparam int VW2 = VWIDTH + 2;
  localparam int CW  = $clog2(INVULN_FRAMES + 1);
  localparam logic signed [VW2-1:0]   MIS     = VW2'(POS_MISMATCH);
  localparam logic signed [VW2-1:0]   OFF     = VW2'(POS_OFFSET);
  localparam logic [COUNT_WIDTH-1:0]  CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [CW-1:0]           FR_ONE  = CW'(1);
  localparam logic [CW-1:0]           FR_LOAD = CW'(INVULN_FRAMES);
  localparam logic [3:0]              LIVES_INIT = 4'(LIVES);

  typedef enum logic [1:0] {S_PLAY = 2'd0, S_INVULN = 2'd1, S_OVER = 2'd2} state_t;

  state_t              state;
  logic [CW-1:0]       frames_left;
  logic [N_OBST-1:0]   consumed;
  logic [N_OBST-1:0]   overlap;
  logic [N_OBST-1:0]   jump_clear;
  logic [N_OBST-1:0]   fresh;
  logic [IW-1:0]       first;
  logic signed [VW2-1:0] diff [N_OBST];
  logic signed [VW2-1:0] mag  [N_OBST];

`ifdef COLLISION_JUMP_EN
  assign jump_clear = obst_low & {N_OBST{player_air}};
`else
  logic unused_jump_inputs;
  assign unused_jump_inputs = ^{player_air, obst_low};
  assign jump_clear = {N_OBST{1'b0}};
`endif

  // Differences are widened by two bits so extreme positions cannot wrap into the window.
  always_comb begin
    overlap = {N_OBST{1'b0}};
    for (int i = 0; i < N_OBST; i++) begin
      diff[i] = {{2{obst_voffset[i][VWIDTH-1]}}, obst_voffset[i]} - MIS
              - {{2{player_voffset[VWIDTH-1]}}, player_voffset};
      mag[i]  = diff[i][VW2-1] ? -diff[i] : diff[i];
      overlap[i] = obst_valid[i] && (obst_lane[i] == player_lane)
                && (mag[i] <= OFF) && !jump_clear[i];
    end
  end

  assign fresh = overlap & ~consumed;

  // Lowest-indexed fresh slot wins when several are hit on the same frame.
  always_comb begin
    first = {IW{1'b0}};
    for (int i = N_OBST - 1; i >= 0; i--) begin
      first = fresh[i] ? IW'(i) : first;
    end
  end

  // Game state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_PLAY;
      frames_left <= {CW{1'b0}};
      consumed    <= {N_OBST{1'b0}};
      hit_pulse   <= 1'b0;
      hit_idx     <= {IW{1'b0}};
      hit_count   <= {COUNT_WIDTH{1'b0}};
      lives       <= LIVES_INIT;
      invuln      <= 1'b0;
      game_over   <= 1'b0;
    end else if (restart) begin
      state       <= S_PLAY;
      frames_left <= {CW{1'b0}};
      consumed    <= {N_OBST{1'b0}};
      hit_pulse   <= 1'b0;
      hit_count   <= {COUNT_WIDTH{1'b0}};
      lives       <= LIVES_INIT;
      invuln      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        S_PLAY: begin
          consumed <= frame_tick ? overlap : (consumed & obst_valid);
          if (frame_tick && (|fresh)) begin
            hit_pulse <= 1'b1;
            hit_idx   <= first;
            hit_count <= (hit_count == CNT_MAX) ? hit_count : hit_count + CNT_ONE;
            lives     <= lives - 4'd1;
            if (lives == 4'd1) begin
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              state       <= S_INVULN;
              invuln      <= 1'b1;
              frames_left <= FR_LOAD;
            end
          end
        end
        S_INVULN: begin
          consumed <= frame_tick ? overlap : (consumed & obst_valid);
          if (frame_tick) begin
            frames_left <= frames_left - FR_ONE;
            if (frames_left == FR_ONE) begin
              state  <= S_PLAY;
              invuln <= 1'b0;
            end
          end
        end
        S_OVER: begin
          consumed <= consumed;
        end
        default: begin
          state     <= S_PLAY;
          invuln    <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_tracker.sv
// Self-checking bench for collision_tracker: directed test-plan steps plus randomized frames
// checked every cycle against a behavioural game model.
module tb_collision_tracker;

  localparam int NO   = 4;
  localparam int LV   = 3;
  localparam int INVF = 3;
  localparam int OFF  = 5;
  localparam int MIS  = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_tick;
  logic              restart;
  logic [1:0]        player_lane;
  logic signed [11:0] player_voffset;
  logic              player_air;
  logic [NO-1:0]     obst_valid;
  logic [1:0]        obst_lane [NO];
  logic signed [11:0] obst_voffset [NO];
  logic [NO-1:0]     obst_low;
  logic              hit_pulse;
  logic [1:0]        hit_idx;
  logic [15:0]       hit_count;
  logic [3:0]        lives;
  logic              invuln;
  logic              game_over;

  collision_tracker #(
    .N_OBST(NO), .VWIDTH(12), .LWIDTH(2), .COUNT_WIDTH(16), .POS_MISMATCH(MIS),
    .POS_OFFSET(OFF), .LIVES(LV), .INVULN_FRAMES(INVF)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .player_lane(player_lane), .player_voffset(player_voffset), .player_air(player_air),
    .obst_valid(obst_valid), .obst_lane(obst_lane), .obst_voffset(obst_voffset),
    .obst_low(obst_low), .hit_pulse(hit_pulse), .hit_idx(hit_idx), .hit_count(hit_count),
    .lives(lives), .invuln(invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Bench-side scene description
  bit valid_b [NO];
  int lane_b  [NO];
  int ov_b    [NO];
  bit low_b   [NO];
  int plane, pv;
  bit air;

  // Reference game model (mode: 0 play, 1 invulnerable, 2 game over)
  int m_mode, m_lives, m_count, m_idx, m_left;
  bit m_pulse;
  bit m_cons [NO];

  int checks = 0;
  int failures = 0;
  int pulses = 0;

`ifdef COLLISION_JUMP_EN
  localparam bit JUMP = 1'b1;
`else
  localparam bit JUMP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic bit touches(int i);
    int d;
    d = ov_b[i] - MIS - pv;
    if (d < 0) d = -d;
    return valid_b[i] && (lane_b[i] == plane) && (d <= OFF) && !(JUMP && low_b[i] && air);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lives = LV; m_count = 0; m_idx = 0; m_left = 0; m_pulse = 1'b0;
    foreach (m_cons[i]) m_cons[i] = 1'b0;
  endtask

  task automatic model(input bit tick, input bit rs);
    int winner;
    bit hits [NO];
    m_pulse = 1'b0;
    if (rs) begin
      m_mode = 0; m_lives = LV; m_count = 0;
      foreach (m_cons[i]) m_cons[i] = 1'b0;
      return;
    end
    if (m_mode == 2) return;
    if (!tick) begin
      foreach (m_cons[i]) m_cons[i] = m_cons[i] && valid_b[i];
      return;
    end
    winner = -1;
    for (int i = 0; i < NO; i++) begin
      hits[i] = touches(i);
      if (hits[i] && !m_cons[i] && winner < 0) winner = i;
    end
    foreach (m_cons[i]) m_cons[i] = hits[i];
    if (m_mode == 0 && winner >= 0) begin
      m_pulse = 1'b1;
      m_idx = winner;
      m_count = (m_count == 65535) ? 65535 : m_count + 1;
      m_lives = m_lives - 1;
      if (m_lives == 0) m_mode = 2;
      else begin m_mode = 1; m_left = INVF; end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hit_pulse"}, 32'(hit_pulse), 32'(m_pulse));
    chk({tag, ".hit_idx"},   32'(hit_idx),   32'(m_idx));
    chk({tag, ".hit_count"}, 32'(hit_count), 32'(m_count));
    chk({tag, ".lives"},     32'(lives),     32'(m_lives));
    chk({tag, ".invuln"},    32'(invuln),    32'(m_mode == 1));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_mode == 2));
  endtask

  task automatic drive();
    for (int i = 0; i < NO; i++) begin
      obst_valid[i]   = valid_b[i];
      obst_lane[i]    = 2'(lane_b[i]);
      obst_voffset[i] = 12'(ov_b[i]);
      obst_low[i]     = low_b[i];
    end
    player_lane = 2'(plane);
    player_voffset = 12'(pv);
    player_air = air;
  endtask

  task automatic step(input bit tick, input bit rs, input string tag);
    drive();
    frame_tick = tick;
    restart = rs;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    restart = 1'b0;
    model(tick, rs);
    if (hit_pulse) pulses++;
    check_all(tag);
  endtask

  task automatic frames(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, tag);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NO; i++) begin
      valid_b[i] = 1'b0; lane_b[i] = 0; ov_b[i] = 0; low_b[i] = 1'b0;
    end
  endtask

  task automatic set_slot(input int i, input int ln, input int v);
    valid_b[i] = 1'b1; lane_b[i] = ln; ov_b[i] = v;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; restart = 1'b0;
    clear_slots(); plane = 1; pv = 103; air = 1'b0;
    drive();
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single obstacle held over five frames
    set_slot(0, 1, 100);
    pulses = 0;
    frames(5, "tp1");
    chk("tp1_pulses", 32'(pulses), 32'd1);
    chk("tp1_count", 32'(hit_count), 32'd1);
    chk("tp1_lives", 32'(lives), 32'd2);

    // Overlaps during invulnerability stay consumed
    valid_b[0] = 1'b0;
    step(1'b0, 1'b0, "tp2_clear");
    set_slot(0, 1, 100);
    step(1'b1, 1'b0, "tp2_hit");
    chk("tp2_invuln", 32'(invuln), 32'd1);
    valid_b[0] = 1'b0;
    set_slot(1, 1, 101);
    pulses = 0;
    frames(2, "tp2_inv");
    step(1'b1, 1'b0, "tp2_third");
    chk("tp2_invuln_drop", 32'(invuln), 32'd0);
    step(1'b1, 1'b0, "tp2_after");
    chk("tp2_pulses", 32'(pulses), 32'd0);

    // Two fresh slots on one frame
    step(1'b0, 1'b1, "restart1");
    clear_slots();
    step(1'b1, 1'b0, "tp3_idle");
    set_slot(1, 1, 100);
    set_slot(3, 1, 98);
    step(1'b1, 1'b0, "tp3");
    chk("tp3_idx", 32'(hit_idx), 32'd1);
    chk("tp3_count", 32'(hit_count), 32'd1);

    // Three separated hits end the game
    step(1'b0, 1'b1, "restart2");
    for (int h = 0; h < 3; h++) begin
      clear_slots();
      frames(4, "tp4_gap");
      set_slot(0, 1, 103);
      step(1'b1, 1'b0, "tp4_hit");
    end
    chk("tp4_lives", 32'(lives), 32'd0);
    chk("tp4_over", 32'(game_over), 32'd1);
    pulses = 0;
    clear_slots(); frames(1, "tp4_over_gap");
    set_slot(2, 1, 104); frames(2, "tp4_over_ovl");
    chk("tp4_over_pulses", 32'(pulses), 32'd0);
    step(1'b1, 1'b1, "tp4_restart_tick");
    chk("tp4_restart_lives", 32'(lives), 32'd3);
    chk("tp4_restart_count", 32'(hit_count), 32'd0);
    step(1'b1, 1'b0, "tp4_post_restart");

    // Window edges and extreme positions
    step(1'b0, 1'b1, "restart3");
    clear_slots(); plane = 0; pv = 0;
    set_slot(2, 0, 5);  step(1'b1, 1'b0, "edge_p5");
    chk("edge_p5_pulse", 32'(hit_pulse), 32'd1);
    clear_slots(); frames(4, "edge_gap");
    set_slot(2, 0, 6);  step(1'b1, 1'b0, "edge_p6");
    chk("edge_p6_pulse", 32'(hit_pulse), 32'd0);
    set_slot(2, 0, -6); step(1'b1, 1'b0, "edge_m6");
    set_slot(2, 0, -5); step(1'b1, 1'b0, "edge_m5");
    clear_slots(); frames(4, "edge_gap2");
    pv = -2048; set_slot(0, 0, 2047); step(1'b1, 1'b0, "wrap_a");
    chk("wrap_a_pulse", 32'(hit_pulse), 32'd0);
    pv = 2047; set_slot(0, 0, -2048); step(1'b1, 1'b0, "wrap_b");

    // Low barriers against an airborne player
    step(1'b0, 1'b1, "restart4");
    clear_slots(); plane = 2; pv = 50; air = 1'b1;
    set_slot(1, 2, 52); low_b[1] = 1'b1;
    step(1'b1, 1'b0, "jump_air");
    chk("jump_air_pulse", 32'(hit_pulse), JUMP ? 32'd0 : 32'd1);
    air = 1'b0;
    frames(4, "jump_ground");

    // Randomized scenes
    step(1'b0, 1'b1, "restart5");
    for (int n = 0; n < 600; n++) begin
      plane = int'($urandom_range(0, 3));
      pv = int'($urandom_range(0, 24)) - 12;
      air = 1'($urandom_range(0, 1));
      for (int i = 0; i < NO; i++) begin
        valid_b[i] = ($urandom_range(0, 3) != 0);
        lane_b[i] = ($urandom_range(0, 1) == 0) ? plane : int'($urandom_range(0, 3));
        ov_b[i] = pv + int'($urandom_range(0, 16)) - 8;
        low_b[i] = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), "rand");
    end

    // Asynchronous reset in the middle of invulnerability
    step(1'b0, 1'b1, "restart6");
    clear_slots(); plane = 1; pv = 0; air = 1'b0;
    set_slot(0, 1, 2);
    step(1'b1, 1'b0, "rst_hit");
    chk("rst_pre_invuln", 32'(invuln), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_tracker.md
# collision_tracker

Multi-obstacle collision tracker for the runner game. It compares the player against `N_OBST` obstacle slots once per frame and raises one hit event per obstacle pass rather than one per clock. It also manages a lives counter, a post-hit invulnerability window and a game-over state. It sits between the obstacle spawner/scroller and the game-state/score logic.

## Interface
- `N_OBST`, 4: number of obstacle slots (1–16).
- `VWIDTH`, 12: signed vertical position width.
- `LWIDTH`, 2: lane index width.
- `COUNT_WIDTH`, 16: hit counter width.
- `POS_MISMATCH`, 0: sprite origin correction subtracted from obstacle position.
- `POS_OFFSET`, 5: half-width of the vertical overlap window.
- `LIVES`, 3: lives loaded at reset and restart (1–15).
- `INVULN_FRAMES`, 30: frame ticks of invulnerability after a hit (≥1).
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `frame_tick` input 1: one-cycle strobe; evaluation happens only on it.
- `restart` input 1: one-cycle strobe; starts a new game.
- `player_lane` input `LWIDTH`: player lane.
- `player_voffset` input `VWIDTH` signed: player vertical position.
- `player_air` input 1: player airborne.
- `obst_valid` input `N_OBST`: slot active.
- `obst_lane` input `N_OBST`×`LWIDTH` unpacked: slot lane.
- `obst_voffset` input `N_OBST`×`VWIDTH` signed unpacked: slot position.
- `obst_low` input `N_OBST`: slot is a jumpable low barrier.
- `hit_pulse` output 1: one-cycle hit event.
- `hit_idx` output `$clog2(N_OBST)` (min 1): slot index of the last hit.
- `hit_count` output `COUNT_WIDTH`: total hits, saturating.
- `lives` output 4: remaining lives.
- `invuln` output 1: invulnerability active.
- `game_over` output 1: game-over state.

## Operation
- Overlap for slot i requires all of the following:
  - `obst_valid[i]`;
  - `obst_lane[i]==player_lane`;
  - `|obst_voffset[i]-POS_MISMATCH-player_voffset| <= POS_OFFSET`, evaluated signed at `VWIDTH+2` bits so there is no wrap.
- Per-slot `consumed[i]` latch:
  - set on a frame tick where slot i overlaps;
  - cleared on a frame tick where slot i does not overlap, or whenever `obst_valid[i]` is low.
- Fresh hit: slot i overlaps and `consumed[i]` was 0. With several fresh hits on one frame tick, the lowest index wins and only one hit is counted. All overlapping slots become consumed.
- States:
  - PLAY
    - A fresh hit → `hit_pulse`, `hit_idx`=i, `hit_count`+1 (saturates at all-ones), `lives`−1.
    - If `lives` becomes 0 → GAME_OVER; otherwise → INVULN and load the frame counter with `INVULN_FRAMES`.
  - INVULN
    - `invuln`=1.
    - Overlaps update `consumed` but produce no hit.
    - Counter decrements on each frame tick; on reaching 0 → PLAY.
  - GAME_OVER
    - `game_over`=1; no evaluation; `consumed` is held.
    - Only `restart` leaves this state.
- `restart` from any state:
  - `lives`=`LIVES`, `hit_count`=0, `consumed`=0, `invuln`=0;
  - → PLAY.
- Reset values: state PLAY, `lives`=`LIVES`, `hit_count`=0, `hit_idx`=0, `hit_pulse`=0, `invuln`=0, `game_over`=0, `consumed`=0.

## Timing
- Inputs are sampled on the `clk` edge where `frame_tick`=1.
- `hit_pulse` and the updated `hit_count`, `lives`, `hit_idx` and state appear one cycle later. `hit_pulse` lasts exactly one cycle.
- `invuln` and `game_over` are registered state decodes, valid in the same cycle as `hit_pulse`.
- `restart` and `frame_tick` in the same cycle: `restart` wins and the frame is ignored.
- `frame_tick` during the `hit_pulse` cycle is evaluated against the new state.
- `rst` asserted mid-game clears everything immediately, with no clock required.

## Configuration
- `COLLISION_JUMP_EN` defined: a slot with `obst_low[i]`=1 never overlaps while `player_air`=1, and its `consumed` latch clears as for a non-overlap.
- Not defined: `player_air` and `obst_low` are ignored. The ports remain present.

## Test plan
- Slot 0 at lane 1, voffset 100; player at lane 1, voffset 103, held for 5 frame ticks → exactly one `hit_pulse`, `hit_count`=1, `lives`=2, `invuln`=1.
- `INVULN_FRAMES`=3: after a hit, slot 1 overlaps on frame ticks 1 and 2 of invulnerability → no pulse. On the 3rd tick `invuln` drops to 0. Slot 1 still overlapping on the next tick → no pulse, because it is already consumed.
- Slots 1 and 3 fresh on the same tick → one pulse, `hit_idx`=1, `hit_count`+1.
- Three separated hits from `LIVES`=3 → `lives`=0, `game_over`=1. Further overlaps → no pulses. `restart` → `lives`=3, `hit_count`=0, PLAY.
- Boundary cases: obstacle at +5 (hit), +6 (no hit), and player −2048 vs obstacle 2047 (no hit, no wrap).
- `COLLISION_JUMP_EN`: `obst_low`=1 with `player_air`=1 → no hit; with `player_air`=0 → hit. Assert `rst` mid-INVULN → all outputs at reset values immediately.
